data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/y86_mem_pkg.sv | 20 ++
 rtl/data_mem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 data-memory responder: word width, default
// geometry/latency and the responder FSM state type.
package y86_mem_pkg;

  localparam int WORD_W          = 64;
  localparam int DEPTH_DEFAULT   = 1024;
  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port data memory: synchronous write, combinational read.
module data_mem_array
  import y86_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = addr_width(DEPTH_DEFAULT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency request/response front end for the Y86 data memory.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module data_mem_responder
  import y86_mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int ADDR_W = addr_width(DEPTH);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               write_q;
  logic [63:0]        addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [WORD_W-1:0]  resp_rdata_q;
  logic               resp_error_q;
  logic               resp_valid_q;
  logic               busy_q;
  logic               req_ready_q;

  logic               addr_err;
  logic               access_now;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_rdata;

  // Full 64-bit compare so high address bits can never alias into the array.
  assign addr_err   = (addr_q >= 64'(DEPTH));
  assign access_now = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we     = access_now && write_q && !addr_err;

  data_mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_W'(LATENCY - 1);
            state_q     <= ST_WAIT;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= addr_err;
            resp_rdata_q <= (write_q || addr_err) ? '0 : mem_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
          busy_q       <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15), vector table,
// corner-case sequences and randomized traffic against an array-based model.
module tb_data_mem_responder;
  import y86_mem_pkg::*;

  localparam int N_DUT = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [N_DUT];
  logic        req_ready  [N_DUT];
  logic        req_write  [N_DUT];
  logic [63:0] req_addr   [N_DUT];
  logic [63:0] req_wdata  [N_DUT];
  logic        resp_valid [N_DUT];
  logic        resp_ready [N_DUT];
  logic [63:0] resp_rdata [N_DUT];
  logic        resp_error [N_DUT];
  logic        busy       [N_DUT];
  logic [1:0]  dbg_state  [N_DUT];

  int check_cnt;
  int err_cnt;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY ((g == 0) ? 2 : (g == 1) ? 1 : 15)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_error (resp_error[g]),
      .busy       (busy[g]),
      .dbg_state  (dbg_state[g])
    );
  end

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", err_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one full transaction on instance k; returns response and measured latency.
  task automatic txn(input int k, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input int hold,
                     output logic [63:0] rdata, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!req_ready[k] && guard < 50) begin
      tick();
      guard++;
    end
    chk("req_ready_before_req", 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    tick();
    req_valid[k] = 1'b0;
    req_addr[k]  = {$urandom, $urandom};
    req_wdata[k] = {$urandom, $urandom};
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      chk("busy_wait", 64'(busy[k]), 64'd1);
      chk("req_ready_wait", 64'(req_ready[k]), 64'd0);
      chk("rdata_zero_wait", resp_rdata[k], 64'd0);
      chk("error_zero_wait", 64'(resp_error[k]), 64'd0);
      tick();
      lat++;
    end
    rdata = resp_rdata[k];
    err   = resp_error[k];
    chk("busy_resp", 64'(busy[k]), 64'd1);
    // Backpressure: new request offered while the response is held
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1;
      tick();
      chk("hold_resp_valid", 64'(resp_valid[k]), 64'd1);
      chk("hold_rdata", resp_rdata[k], rdata);
      chk("hold_error", 64'(resp_error[k]), 64'(err));
      chk("hold_busy", 64'(busy[k]), 64'd1);
      chk("hold_req_ready", 64'(req_ready[k]), 64'd0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
    chk("post_resp_valid", 64'(resp_valid[k]), 64'd0);
    chk("post_rdata", resp_rdata[k], 64'd0);
    chk("post_error", 64'(resp_error[k]), 64'd0);
    chk("post_req_ready", 64'(req_ready[k]), 64'd1);
    chk("post_busy", 64'(busy[k]), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Scoreboard model: word array of in-range addresses known to the bench
  logic [63:0] model_mem [longint];

  function automatic logic model_err(input logic [63:0] a);
    return a >= 64'(DEPTH);
  endfunction

  initial begin
    vec_t        vecs [$];
    logic [63:0] exp_q [$];
    logic [63:0] pool [8];
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rd;

    check_cnt = 0;
    err_cnt   = 0;
    pool = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd5, 64'd7, 64'd1022, 64'd1023};

    // Clock/reset block
    rst_n = 1'b0;
    for (int k = 0; k < N_DUT; k++) begin
      req_valid[k]  = 1'b0;
      req_write[k]  = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      resp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      chk("reset_resp_valid", 64'(resp_valid[k]), 64'd0);
      chk("reset_rdata", resp_rdata[k], 64'd0);
      chk("reset_error", 64'(resp_error[k]), 64'd0);
      chk("reset_busy", 64'(busy[k]), 64'd0);
      chk("reset_state", 64'(dbg_state[k]), 64'(ST_IDLE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < N_DUT; k++) chk("reset_req_ready", 64'(req_ready[k]), 64'd1);

    // Vector table on the LATENCY=2 instance
    foreach (pool[i]) vecs.push_back('{1'b1, pool[i], 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b1, 64'd5, 64'hDEAD_BEEF, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'd5, 64'd0, 64'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 64'd1023, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'd1024, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'h1_0000_0005, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{1'b1, 64'd2048, 64'h1234, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'd1023, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b1, 64'h8000_0000_0000_0007, 64'h77, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'd7, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'd5, 64'd0, 64'hDEAD_BEEF, 1'b0});
    foreach (vecs[i]) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_error", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      if (vecs[i].wr && !model_err(vecs[i].addr)) model_mem[longint'(vecs[i].addr)] = vecs[i].wdata;
    end

    // Backpressure: 4 held cycles with a competing request
    txn(0, 1'b0, 64'd5, 64'd0, 4, rd, er, lat);
    chk("bp_rdata", rd, 64'hDEAD_BEEF);
    chk("bp_error", 64'(er), 64'd0);

    // Reset while a store is in WAIT
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 64'd7;
    req_wdata[0] = 64'h55;
    tick();
    req_valid[0] = 1'b0;
    chk("rst_mid_busy_before", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst_mid_rdata", resp_rdata[0], 64'd0);
    chk("rst_mid_error", 64'(resp_error[0]), 64'd0);
    chk("rst_mid_busy", 64'(busy[0]), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_mid_busy_after", 64'(busy[0]), 64'd0);
    txn(0, 1'b0, 64'd7, 64'd0, 0, rd, er, lat);
    chk("rst_mid_load7", rd, 64'd0);
    chk("rst_mid_load7_err", 64'(er), 64'd0);

    // Latency sweep on LATENCY=1 and LATENCY=15 instances
    for (int k = 1; k < N_DUT; k++) begin
      wd = {$urandom, $urandom};
      txn(k, 1'b1, 64'd9, wd, 0, rd, er, lat);
      chk($sformatf("sweep%0d_store_latency", lat_of(k)), 64'(lat), 64'(lat_of(k)));
      chk($sformatf("sweep%0d_store_rdata", lat_of(k)), rd, 64'd0);
      txn(k, 1'b0, 64'd9, 64'd0, 1, rd, er, lat);
      chk($sformatf("sweep%0d_load_latency", lat_of(k)), 64'(lat), 64'(lat_of(k)));
      chk($sformatf("sweep%0d_load_rdata", lat_of(k)), rd, wd);
      chk($sformatf("sweep%0d_load_error", lat_of(k)), 64'(er), 64'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      if (sel < 8)       a = pool[sel];
      else if (sel == 8) a = 64'(DEPTH) + 64'($urandom_range(0, 3));
      else begin
        a = {$urandom, $urandom};
        if (a < 64'(DEPTH)) a = a + 64'(DEPTH);
      end
      exp_rd = (!wr && !model_err(a)) ? model_mem[longint'(a)] : 64'd0;
      exp_q.push_back(exp_rd);
      txn(0, wr, a, wd, int'($urandom_range(0, 3)), rd, er, lat);
      chk($sformatf("rand%0d_rdata", n), rd, exp_q.pop_front());
      chk($sformatf("rand%0d_error", n), 64'(er), 64'(model_err(a)));
      chk($sformatf("rand%0d_latency", n), 64'(lat), 64'd2);
      if (wr && !model_err(a)) model_mem[longint'(a)] = wd;
      repeat ($urandom_range(0, 2)) tick();
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
